// File: rtl/game_pkg.sv
// Shared types and widths for the cat-vs-dog turn sequencer.
package game_pkg;

  localparam int HP_W   = 3;
  localparam int SECS_W = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    TURN  = 3'd1,
    LAND  = 3'd2,
    CHECK = 3'd3,
    PAUSE = 3'd4,
    OVER  = 3'd5
  } sched_state_t;

  typedef enum logic {
    PLAYER_DOG = 1'b0,
    PLAYER_CAT = 1'b1
  } player_t;

  // Hit points never wrap below zero.
  function automatic logic [HP_W-1:0] hp_after_hit(input logic [HP_W-1:0] hp, input logic hit);
    if (hit && (hp != '0)) return hp - 1'b1;
    return hp;
  endfunction

endpackage

// File: rtl/turn_scheduler_sec_tick_gen.sv
// Seconds prescaler: counts 0..CLK_HZ-1 and emits a one-cycle tick on the wrap.
module sec_tick_gen #(
  parameter int CLK_HZ = 65000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_HZ - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap;

  assign wrap = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || wrap) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // A cleared prescaler restarts at 0, so the first tick of a turn is a full second away.
  assign tick = wrap && !clr;

endmodule

// File: rtl/turn_scheduler.sv
// Turn sequencer: alternates dog/cat turns, enforces the turn time limit,
// waits for the projectile to land, applies damage and declares the winner.
module turn_scheduler
  import game_pkg::*;
#(
  parameter int CLK_HZ       = 65000000,
  parameter int TURN_SECS    = 10,
  parameter int LAND_CYCLES  = 130000000,
  parameter int PAUSE_CYCLES = 32500000,
  parameter int HP_INIT      = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dog_done,
  input  logic              cat_done,
  input  logic              proj_landed,
  input  logic              hit_dog,
  input  logic              hit_cat,
  output logic              dog_turn,
  output logic              cat_turn,
  output logic [SECS_W-1:0] secs_left,
  output logic              turn_timeout,
  output logic [HP_W-1:0]   dog_hp,
  output logic [HP_W-1:0]   cat_hp,
  output logic              game_over,
  output logic              winner,
  output sched_state_t      dbg_state
);

  localparam int LW = (LAND_CYCLES > 1) ? $clog2(LAND_CYCLES) : 1;
  localparam int PW = (PAUSE_CYCLES > 1) ? $clog2(PAUSE_CYCLES) : 1;
  localparam logic [LW-1:0]     LAND_LAST   = LW'(LAND_CYCLES - 1);
  localparam logic [PW-1:0]     PAUSE_LAST  = PW'(PAUSE_CYCLES - 1);
  localparam logic [HP_W-1:0]   HP_RELOAD   = HP_W'(HP_INIT);
  localparam logic [SECS_W-1:0] SECS_RELOAD = SECS_W'(TURN_SECS);

  sched_state_t      state_q;
  player_t           shooter_q, winner_q;
  logic              dog_turn_q, cat_turn_q, timeout_q, over_q;
  logic [SECS_W-1:0] secs_q;
  logic [HP_W-1:0]   dog_hp_q, cat_hp_q;
  logic [LW-1:0]     land_cnt_q;
  logic [PW-1:0]     pause_cnt_q;

  logic [HP_W-1:0]   dog_hp_d, cat_hp_d;
  player_t           winner_d, next_shooter;
  logic              owner_done, sec_tick;

  sec_tick_gen #(.CLK_HZ(CLK_HZ)) u_sec_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q != TURN),
    .tick (sec_tick)
  );

  // Inputs other than rst are one-cycle pulses sampled on the clock edge;
  // anything arriving in a state that does not listen for it is dropped.
  assign owner_done   = (shooter_q == PLAYER_DOG) ? dog_done : cat_done;
  assign next_shooter = (shooter_q == PLAYER_DOG) ? PLAYER_CAT : PLAYER_DOG;
  assign dog_hp_d     = hp_after_hit(dog_hp_q, hit_dog);
  assign cat_hp_d     = hp_after_hit(cat_hp_q, hit_cat);

  always_comb begin
    winner_d = PLAYER_DOG;
    if ((dog_hp_q == '0) && (cat_hp_q == '0)) winner_d = shooter_q;
    else if (dog_hp_q == '0)                  winner_d = PLAYER_CAT;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shooter_q   <= PLAYER_DOG;
      winner_q    <= PLAYER_DOG;
      dog_turn_q  <= 1'b0;
      cat_turn_q  <= 1'b0;
      timeout_q   <= 1'b0;
      over_q      <= 1'b0;
      secs_q      <= '0;
      dog_hp_q    <= HP_RELOAD;
      cat_hp_q    <= HP_RELOAD;
      land_cnt_q  <= '0;
      pause_cnt_q <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE, OVER: begin
          if (start) begin
            state_q    <= TURN;
            shooter_q  <= PLAYER_DOG;
            winner_q   <= PLAYER_DOG;
            dog_turn_q <= 1'b1;
            cat_turn_q <= 1'b0;
            over_q     <= 1'b0;
            secs_q     <= SECS_RELOAD;
            dog_hp_q   <= HP_RELOAD;
            cat_hp_q   <= HP_RELOAD;
          end
        end
        TURN: begin
          if (owner_done) begin
            state_q    <= LAND;
            dog_turn_q <= 1'b0;
            cat_turn_q <= 1'b0;
            secs_q     <= '0;
            land_cnt_q <= '0;
          end else if (sec_tick) begin
            if (secs_q <= SECS_W'(1)) begin
              state_q     <= PAUSE;
              timeout_q   <= 1'b1;
              dog_turn_q  <= 1'b0;
              cat_turn_q  <= 1'b0;
              secs_q      <= '0;
              pause_cnt_q <= '0;
            end else begin
              secs_q <= secs_q - 1'b1;
            end
          end
        end
        LAND: begin
          if (proj_landed) begin
            state_q  <= CHECK;
            dog_hp_q <= dog_hp_d;
            cat_hp_q <= cat_hp_d;
          end else if (land_cnt_q == LAND_LAST) begin
            state_q     <= PAUSE;
            pause_cnt_q <= '0;
          end else begin
            land_cnt_q <= land_cnt_q + 1'b1;
          end
        end
        CHECK: begin
          if ((dog_hp_q == '0) || (cat_hp_q == '0)) begin
            state_q  <= OVER;
            over_q   <= 1'b1;
            winner_q <= winner_d;
          end else begin
            state_q     <= PAUSE;
            pause_cnt_q <= '0;
          end
        end
        PAUSE: begin
          if (pause_cnt_q == PAUSE_LAST) begin
            state_q    <= TURN;
            shooter_q  <= next_shooter;
            dog_turn_q <= (next_shooter == PLAYER_DOG);
            cat_turn_q <= (next_shooter == PLAYER_CAT);
            secs_q     <= SECS_RELOAD;
          end else begin
            pause_cnt_q <= pause_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dog_turn     = dog_turn_q;
  assign cat_turn     = cat_turn_q;
  assign secs_left    = secs_q;
  assign turn_timeout = timeout_q;
  assign dog_hp       = dog_hp_q;
  assign cat_hp       = cat_hp_q;
  assign game_over    = over_q;
  assign winner       = (winner_q == PLAYER_CAT);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_turn_scheduler.sv
// Table-driven bench for turn_scheduler with small timing parameters.
module tb_turn_scheduler;
  import game_pkg::*;

  localparam int EW = 19;

  // Input encoding {rst, start, dog_done, cat_done, proj_landed, hit_dog, hit_cat}
  localparam logic [6:0] I_NONE  = 7'b0000000;
  localparam logic [6:0] I_RST   = 7'b1000000;
  localparam logic [6:0] I_START = 7'b0100000;
  localparam logic [6:0] I_DD    = 7'b0010000;
  localparam logic [6:0] I_CD    = 7'b0001000;
  localparam logic [6:0] I_LAND  = 7'b0000100;
  localparam logic [6:0] I_HD    = 7'b0000010;
  localparam logic [6:0] I_HC    = 7'b0000001;

  typedef struct {
    logic [6:0]    in;
    int            k;
    logic [EW-1:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst, start, dog_done, cat_done, proj_landed, hit_dog, hit_cat;
  logic dog_turn, cat_turn, turn_timeout, game_over, winner;
  logic [SECS_W-1:0] secs_left;
  logic [HP_W-1:0] dog_hp, cat_hp;
  sched_state_t dbg_state;

  logic [EW-1:0] exp_q[$];
  vec_t tbl[$];
  int total = 0;
  int bad = 0;
  int to_count = 0;

  turn_scheduler #(
    .CLK_HZ(10), .TURN_SECS(3), .LAND_CYCLES(20), .PAUSE_CYCLES(4), .HP_INIT(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .dog_done(dog_done), .cat_done(cat_done),
    .proj_landed(proj_landed), .hit_dog(hit_dog), .hit_cat(hit_cat),
    .dog_turn(dog_turn), .cat_turn(cat_turn), .secs_left(secs_left),
    .turn_timeout(turn_timeout), .dog_hp(dog_hp), .cat_hp(cat_hp),
    .game_over(game_over), .winner(winner), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) if (!rst && turn_timeout) to_count++;

  function automatic logic [EW-1:0] pk(input sched_state_t st, input logic dt, input logic ct,
                                       input int secs, input logic to, input int dh, input int ch,
                                       input logic ov, input logic wn);
    return {st, dt, ct, SECS_W'(secs), to, HP_W'(dh), HP_W'(ch), ov, wn};
  endfunction

  task automatic add(input logic [6:0] in, input int k, input sched_state_t st, input logic dt,
                     input logic ct, input int secs, input logic to, input int dh, input int ch,
                     input logic ov, input logic wn);
    vec_t v;
    v.in  = in;
    v.k   = k;
    v.exp = pk(st, dt, ct, secs, to, dh, ch, ov, wn);
    tbl.push_back(v);
  endtask

  // Scoreboard compare: pops the oldest expectation against the current outputs.
  task automatic check(input string name);
    logic [EW-1:0] got, want;
    got = {dbg_state, dog_turn, cat_turn, secs_left, turn_timeout, dog_hp, cat_hp, game_over, winner};
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s: no expectation queued, got=%h", name, got);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        bad++;
        $display("FAIL %s: got st=%0d dt=%b ct=%b secs=%0d to=%b dhp=%0d chp=%0d over=%b win=%b, want %h (got %h)",
                 name, got[18:16], got[15], got[14], got[13:9], got[8], got[7:5], got[4:2], got[1], got[0],
                 want, got);
      end
    end
  endtask

  // Driver: called at a falling edge; pulses inputs for one clock, idles k more, then compares.
  task automatic step(input logic [6:0] in, input int k, input logic [EW-1:0] exp, input string name);
    {rst, start, dog_done, cat_done, proj_landed, hit_dog, hit_cat} = in;
    exp_q.push_back(exp);
    @(negedge clk);
    {rst, start, dog_done, cat_done, proj_landed, hit_dog, hit_cat} = I_NONE;
    repeat (k) @(negedge clk);
    check(name);
  endtask

  initial begin
    {rst, start, dog_done, cat_done, proj_landed, hit_dog, hit_cat} = I_RST;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(pk(IDLE, 0, 0, 0, 0, 2, 2, 0, 0));
    check("reset");

    //  in                     k   state  dt ct s  to dh ch ov wn
    add(I_START,               0,  TURN,  1, 0, 3, 0, 2, 2, 0, 0);
    add(I_CD,                  0,  TURN,  1, 0, 3, 0, 2, 2, 0, 0);
    add(I_DD,                  0,  LAND,  0, 0, 0, 0, 2, 2, 0, 0);
    add(I_LAND | I_HC,         0,  CHECK, 0, 0, 0, 0, 2, 1, 0, 0);
    add(I_NONE,                3,  PAUSE, 0, 0, 0, 0, 2, 1, 0, 0);
    add(I_NONE,                0,  TURN,  0, 1, 3, 0, 2, 1, 0, 0);
    add(I_NONE,                8,  TURN,  0, 1, 3, 0, 2, 1, 0, 0);
    add(I_NONE,                0,  TURN,  0, 1, 2, 0, 2, 1, 0, 0);
    add(I_NONE,                9,  TURN,  0, 1, 1, 0, 2, 1, 0, 0);
    add(I_NONE,                8,  TURN,  0, 1, 1, 0, 2, 1, 0, 0);
    add(I_NONE,                0,  PAUSE, 0, 0, 0, 1, 2, 1, 0, 0);
    add(I_NONE,                0,  PAUSE, 0, 0, 0, 0, 2, 1, 0, 0);
    add(I_NONE,                1,  PAUSE, 0, 0, 0, 0, 2, 1, 0, 0);
    add(I_NONE,                0,  TURN,  1, 0, 3, 0, 2, 1, 0, 0);
    add(I_START,               0,  TURN,  1, 0, 3, 0, 2, 1, 0, 0);
    add(I_LAND | I_HD | I_HC,  0,  TURN,  1, 0, 3, 0, 2, 1, 0, 0);
    add(I_NONE,               26,  TURN,  1, 0, 1, 0, 2, 1, 0, 0);
    add(I_DD,                  0,  LAND,  0, 0, 0, 0, 2, 1, 0, 0);
    add(I_NONE,               17,  LAND,  0, 0, 0, 0, 2, 1, 0, 0);
    add(I_NONE,                0,  LAND,  0, 0, 0, 0, 2, 1, 0, 0);
    add(I_NONE,                0,  PAUSE, 0, 0, 0, 0, 2, 1, 0, 0);
    add(I_NONE,                2,  PAUSE, 0, 0, 0, 0, 2, 1, 0, 0);
    add(I_NONE,                0,  TURN,  0, 1, 3, 0, 2, 1, 0, 0);
    add(I_DD,                  0,  TURN,  0, 1, 3, 0, 2, 1, 0, 0);
    add(I_CD,                  0,  LAND,  0, 0, 0, 0, 2, 1, 0, 0);
    add(I_LAND | I_HD,         0,  CHECK, 0, 0, 0, 0, 1, 1, 0, 0);
    add(I_NONE,                0,  PAUSE, 0, 0, 0, 0, 1, 1, 0, 0);
    add(I_NONE,                3,  TURN,  1, 0, 3, 0, 1, 1, 0, 0);
    add(I_DD,                  0,  LAND,  0, 0, 0, 0, 1, 1, 0, 0);
    add(I_LAND | I_HC,         0,  CHECK, 0, 0, 0, 0, 1, 0, 0, 0);
    add(I_NONE,                0,  OVER,  0, 0, 0, 0, 1, 0, 1, 0);
    add(I_LAND | I_HD,         0,  OVER,  0, 0, 0, 0, 1, 0, 1, 0);
    add(I_CD,                  2,  OVER,  0, 0, 0, 0, 1, 0, 1, 0);
    add(I_START,               0,  TURN,  1, 0, 3, 0, 2, 2, 0, 0);
    add(I_DD,                  0,  LAND,  0, 0, 0, 0, 2, 2, 0, 0);
    add(I_LAND | I_HD | I_HC,  0,  CHECK, 0, 0, 0, 0, 1, 1, 0, 0);
    add(I_NONE,                4,  TURN,  0, 1, 3, 0, 1, 1, 0, 0);
    add(I_CD,                  0,  LAND,  0, 0, 0, 0, 1, 1, 0, 0);
    add(I_LAND,                0,  CHECK, 0, 0, 0, 0, 1, 1, 0, 0);
    add(I_NONE,                4,  TURN,  1, 0, 3, 0, 1, 1, 0, 0);
    add(I_DD,                  0,  LAND,  0, 0, 0, 0, 1, 1, 0, 0);
    add(I_LAND | I_HD | I_HC,  0,  CHECK, 0, 0, 0, 0, 0, 0, 0, 0);
    add(I_NONE,                0,  OVER,  0, 0, 0, 0, 0, 0, 1, 0);
    add(I_START,               0,  TURN,  1, 0, 3, 0, 2, 2, 0, 0);
    add(I_DD,                  0,  LAND,  0, 0, 0, 0, 2, 2, 0, 0);
    add(I_LAND | I_HD | I_HC,  0,  CHECK, 0, 0, 0, 0, 1, 1, 0, 0);
    add(I_NONE,                4,  TURN,  0, 1, 3, 0, 1, 1, 0, 0);
    add(I_CD,                  0,  LAND,  0, 0, 0, 0, 1, 1, 0, 0);
    add(I_LAND | I_HD | I_HC,  0,  CHECK, 0, 0, 0, 0, 0, 0, 0, 0);
    add(I_NONE,                0,  OVER,  0, 0, 0, 0, 0, 0, 1, 1);
    add(I_START,               0,  TURN,  1, 0, 3, 0, 2, 2, 0, 0);

    foreach (tbl[i]) step(tbl[i].in, tbl[i].k, tbl[i].exp, $sformatf("vec%0d", i));

    // Landing on the last allowed cycle still counts, then reset from PAUSE.
    step(I_DD,          0, pk(LAND,  0, 0, 0, 0, 2, 2, 0, 0), "land_entry");
    step(I_NONE,       18, pk(LAND,  0, 0, 0, 0, 2, 2, 0, 0), "land_last_cycle");
    step(I_LAND | I_HC, 0, pk(CHECK, 0, 0, 0, 0, 2, 1, 0, 0), "land_at_limit");
    step(I_NONE,        0, pk(PAUSE, 0, 0, 0, 0, 2, 1, 0, 0), "pause_entry");
    step(I_RST,         0, pk(IDLE,  0, 0, 0, 0, 2, 2, 0, 0), "rst_in_pause");
    // Reset during LAND.
    step(I_START,       0, pk(TURN,  1, 0, 3, 0, 2, 2, 0, 0), "restart_a");
    step(I_DD,          0, pk(LAND,  0, 0, 0, 0, 2, 2, 0, 0), "land_again");
    step(I_RST,         0, pk(IDLE,  0, 0, 0, 0, 2, 2, 0, 0), "rst_in_land");
    step(I_START,       0, pk(TURN,  1, 0, 3, 0, 2, 2, 0, 0), "restart_b");

    total++;
    if (to_count != 1) begin
      bad++;
      $display("FAIL timeout_pulses: got %0d, want 1", to_count);
    end

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d expectations left, want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
